tx_resp_arb: RTL and testbench
==============================

TX_RESP_ARB -- requirements
Module: tx_resp_arb

Interface
REQ-001 Parameter: DATA_WIDTH, 8, byte width of the FIFO write port; the ALU result width SHALL be 2*DATA_WIDTH.
REQ-002 CLK  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 RST  input  1  reset, asynchronous assert, active-low.
REQ-004 ALU_OUT  input  2*DATA_WIDTH  ALU result.
REQ-005 OUT_Valid  input  1  one-cycle pulse; ALU_OUT is valid in the same cycle.
REQ-006 RdData  input  DATA_WIDTH  register-file read data.
REQ-007 RdData_Valid  input  1  one-cycle pulse; RdData is valid in the same cycle.
REQ-008 wfull  input  1  TX FIFO full flag, in the CLK domain.
REQ-009 TX_P_DATA  output  DATA_WIDTH  registered byte to the FIFO.
REQ-010 TX_D_VLD  output  1  registered FIFO write strobe, one cycle per byte.
REQ-011 BUSY  output  1  high while any request is pending or a transfer is in progress.
REQ-012 OVF  output  1  sticky flag for a dropped request.

Function
REQ-013 Holding buffers: one ALU entry (2*DATA_WIDTH bits plus ALU_PEND) and one register entry (DATA_WIDTH bits plus REG_PEND).
REQ-014 Capture: a valid pulse with its pending flag clear SHALL load the buffer and set the pending flag at that edge.
REQ-015 Simultaneous capture: OUT_Valid and RdData_Valid in the same cycle SHALL capture both entries.
REQ-016 Overflow: a valid pulse while its pending flag is set, and not cleared at the same edge, SHALL be dropped and SHALL set OVF.
REQ-017 Clear-and-capture: if the pending flag is cleared at the same edge as a new valid pulse, the new data SHALL be captured.
REQ-018 FSM states: IDLE, ALU_HI.
REQ-019 IDLE with no pending flag: TX_D_VLD=0 next cycle.
REQ-020 IDLE with exactly one pending flag and wfull=0: grant that requester.
REQ-021 IDLE with both pending flags and wfull=0: round-robin grant to the requester not granted last, tracked by LAST_GNT; reset value of LAST_GNT is ALU, so REG wins the first tie.
REQ-022 REG grant: at that edge, TX_P_DATA<=REG byte, TX_D_VLD<=1, REG_PEND<=0, remain IDLE.
REQ-023 ALU grant: at that edge, TX_P_DATA<=ALU_OUT low byte, TX_D_VLD<=1, go to ALU_HI.
REQ-024 ALU_HI with wfull=0: TX_P_DATA<=high byte, TX_D_VLD<=1, ALU_PEND<=0, go to IDLE.
REQ-025 Byte order for ALU results: low byte first, high byte second; a REG byte SHALL never be inserted between them.
REQ-026 Stall: wfull=1 at an edge SHALL leave the state and buffers unchanged, with TX_D_VLD<=0 and TX_P_DATA held.
REQ-027 Latency: a valid pulse sampled at edge E0 with wfull=0 and no competing grant SHALL give TX_D_VLD high in the cycle after E1; the ALU high byte SHALL follow in the next cycle.
REQ-028 Throughput: one byte per cycle while wfull=0.
REQ-029 TX_D_VLD SHALL be high for exactly one cycle per byte and never high at an edge where wfull was 1.
REQ-030 BUSY = ALU_PEND | REG_PEND | (state != IDLE), combinational.

Reset
REQ-031 RST low SHALL asynchronously force: state IDLE, ALU_PEND=0, REG_PEND=0, LAST_GNT=ALU, TX_D_VLD=0, TX_P_DATA=0, OVF=0.
REQ-032 Reset mid-transfer (in ALU_HI) SHALL abandon the high byte; no TX_D_VLD SHALL occur until a new valid pulse is received.
REQ-033 OVF SHALL clear only on reset.

Verification
REQ-034 Single register read: RdData=0xA5 pulse, wfull=0 -> TX_D_VLD one cycle, 2 cycles later, with TX_P_DATA=0xA5; BUSY then low.
REQ-035 ALU result: ALU_OUT=0x1234 pulse -> bytes 0x34 then 0x12 on consecutive cycles.
REQ-036 Simultaneous pulses after reset: RdData=0x55 and ALU_OUT=0xBEEF -> byte sequence 0x55, 0xEF, 0xBE.
REQ-037 Stall: wfull=1 for 5 cycles between the ALU low and high bytes -> no strobe during the stall; high byte appears 1 cycle after wfull falls.
REQ-038 Overflow: two RdData_Valid pulses while wfull=1 -> first byte kept, OVF=1, a single byte is sent after wfull falls.
REQ-039 Reset asserted in ALU_HI -> outputs return to reset values immediately; no high byte is emitted afterwards.

Source files
------------

// File: rtl/tx_resp_arb.sv
// Response arbiter: buffers one ALU result and one register-read byte and
// serialises them into the TX FIFO, ALU results as low byte then high byte.
module tx_resp_arb #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    OUT_Valid,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_Valid,
   input  logic                    wfull,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   output logic                    BUSY,
   output logic                    OVF
);

   typedef enum logic {StIdle, StAluHi} state_e;

   state_e                  state_q, state_d;
   logic [2*DATA_WIDTH-1:0] alu_buf_q, alu_buf_d;
   logic [DATA_WIDTH-1:0]   reg_buf_q, reg_buf_d;
   logic                    alu_pend_q, alu_pend_d;
   logic                    reg_pend_q, reg_pend_d;
   logic                    last_gnt_alu_q, last_gnt_alu_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_vld_q, tx_vld_d;
   logic                    ovf_q, ovf_d;

   logic gnt_reg, gnt_alu, alu_done;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q        <= StIdle;
         alu_buf_q      <= '0;
         reg_buf_q      <= '0;
         alu_pend_q     <= 1'b0;
         reg_pend_q     <= 1'b0;
         last_gnt_alu_q <= 1'b1;
         tx_data_q      <= '0;
         tx_vld_q       <= 1'b0;
         ovf_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         alu_buf_q      <= alu_buf_d;
         reg_buf_q      <= reg_buf_d;
         alu_pend_q     <= alu_pend_d;
         reg_pend_q     <= reg_pend_d;
         last_gnt_alu_q <= last_gnt_alu_d;
         tx_data_q      <= tx_data_d;
         tx_vld_q       <= tx_vld_d;
         ovf_q          <= ovf_d;
      end
   end

   // Grants only happen when the FIFO can accept; REG wins a tie unless it was served last.
   always_comb begin
      state_d  = state_q;
      gnt_reg  = 1'b0;
      gnt_alu  = 1'b0;
      alu_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!wfull) begin
               if (reg_pend_q && (!alu_pend_q || last_gnt_alu_q)) begin
                  gnt_reg = 1'b1;
               end else if (alu_pend_q) begin
                  gnt_alu = 1'b1;
                  state_d = StAluHi;
               end
            end
         end
         StAluHi: begin
            if (!wfull) begin
               alu_done = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_data_d      = tx_data_q;
      tx_vld_d       = 1'b0;
      last_gnt_alu_d = last_gnt_alu_q;
      reg_buf_d      = reg_buf_q;
      alu_buf_d      = alu_buf_q;
      reg_pend_d     = reg_pend_q && !gnt_reg;
      alu_pend_d     = alu_pend_q && !alu_done;
      ovf_d          = ovf_q;

      if (gnt_reg) begin
         tx_data_d      = reg_buf_q;
         tx_vld_d       = 1'b1;
         last_gnt_alu_d = 1'b0;
      end else if (gnt_alu) begin
         tx_data_d      = alu_buf_q[DATA_WIDTH-1:0];
         tx_vld_d       = 1'b1;
         last_gnt_alu_d = 1'b1;
      end else if (alu_done) begin
         tx_data_d = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
         tx_vld_d  = 1'b1;
      end

      // A slot freed at this edge may be refilled at the same edge.
      if (RdData_Valid) begin
         if (!reg_pend_q || gnt_reg) begin
            reg_buf_d  = RdData;
            reg_pend_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
      if (OUT_Valid) begin
         if (!alu_pend_q || alu_done) begin
            alu_buf_d  = ALU_OUT;
            alu_pend_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign OVF       = ovf_q;
   assign BUSY      = alu_pend_q | reg_pend_q | (state_q != StIdle);

endmodule

// File: tb/tb_tx_resp_arb.sv
// Bench for tx_resp_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a request-level reference model.
module tb_tx_resp_arb;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [2*DW-1:0] ALU_OUT;
   logic          OUT_Valid;
   logic [DW-1:0] RdData;
   logic          RdData_Valid;
   logic          wfull;
   logic [DW-1:0] TX_P_DATA;
   logic          TX_D_VLD;
   logic          BUSY;
   logic          OVF;

   tx_resp_arb #(.DATA_WIDTH(DW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ALU_OUT      (ALU_OUT),
      .OUT_Valid    (OUT_Valid),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .wfull        (wfull),
      .TX_P_DATA    (TX_P_DATA),
      .TX_D_VLD     (TX_D_VLD),
      .BUSY         (BUSY),
      .OVF          (OVF)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: two request slots, an owed high byte, and the last winner.
   bit m_alu_pend, m_reg_pend, m_hi_owed, m_last_alu, m_ovf, m_vld;
   int m_alu_val, m_reg_val, m_data;
   int seen[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_alu_pend = 0; m_reg_pend = 0; m_hi_owed = 0; m_last_alu = 1;
      m_ovf = 0; m_vld = 0; m_data = 0; m_alu_val = 0; m_reg_val = 0;
   endtask

   task automatic model_step();
      bit clr_reg = 0;
      bit clr_alu = 0;
      m_vld = 0;
      if (!wfull) begin
         if (m_hi_owed) begin
            m_data = (m_alu_val >> 8) & 8'hff; m_vld = 1; m_hi_owed = 0; clr_alu = 1;
         end else if (m_reg_pend && (!m_alu_pend || m_last_alu)) begin
            m_data = m_reg_val; m_vld = 1; clr_reg = 1; m_last_alu = 0;
         end else if (m_alu_pend) begin
            m_data = m_alu_val & 8'hff; m_vld = 1; m_hi_owed = 1; m_last_alu = 1;
         end
      end
      if (RdData_Valid) begin
         if (!m_reg_pend || clr_reg) begin
            m_reg_val = RdData; m_reg_pend = 1; clr_reg = 0;
         end else m_ovf = 1;
      end
      if (clr_reg) m_reg_pend = 0;
      if (OUT_Valid) begin
         if (!m_alu_pend || clr_alu) begin
            m_alu_val = ALU_OUT; m_alu_pend = 1; clr_alu = 0;
         end else m_ovf = 1;
      end
      if (clr_alu) m_alu_pend = 0;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      chk("vld", TX_D_VLD, m_vld);
      chk("data", TX_P_DATA, m_data);
      chk("busy", BUSY, m_alu_pend | m_reg_pend | m_hi_owed);
      chk("ovf", OVF, m_ovf);
      if (TX_D_VLD === 1'b1) seen.push_back(int'(TX_P_DATA));
      OUT_Valid    = 1'b0;
      RdData_Valid = 1'b0;
   endtask

   // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
   task automatic do_reset();
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      chk("rst_vld", TX_D_VLD, 0);
      chk("rst_data", TX_P_DATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ovf", OVF, 0);
      @(posedge CLK);
      #2;
      RST = 1'b1;
   endtask

   task automatic chk_seq(input string tag, input int n, input int e0, input int e1, input int e2);
      int exp[3];
      exp[0] = e0; exp[1] = e1; exp[2] = e2;
      chk({tag, "_len"}, seen.size(), n);
      for (int i = 0; i < n && i < seen.size(); i++) chk({tag, "_byte"}, seen[i], exp[i]);
   endtask

   initial begin
      RST = 1'b1; ALU_OUT = '0; OUT_Valid = 0; RdData = '0; RdData_Valid = 0; wfull = 0;
      model_reset();
      #1;
      do_reset();

      // Single register read: strobe two cycles after the pulse.
      seen.delete();
      RdData = 8'hA5; RdData_Valid = 1;
      tick();
      chk("rd_lat1", TX_D_VLD, 0);
      tick();
      chk("rd_lat2", TX_D_VLD, 1);
      chk("rd_data", TX_P_DATA, 8'hA5);
      tick();
      chk("rd_busy", BUSY, 0);
      chk_seq("rd_seq", 1, 8'hA5, 0, 0);

      // ALU result, low byte then high byte.
      seen.delete();
      ALU_OUT = 16'h1234; OUT_Valid = 1;
      repeat (4) tick();
      chk_seq("alu_seq", 2, 8'h34, 8'h12, 0);

      // Simultaneous pulses after reset: REG wins the first tie.
      do_reset();
      seen.delete();
      RdData = 8'h55; RdData_Valid = 1; ALU_OUT = 16'hBEEF; OUT_Valid = 1;
      repeat (5) tick();
      chk_seq("sim_seq", 3, 8'h55, 8'hEF, 8'hBE);

      // Stall between low and high byte.
      do_reset();
      seen.delete();
      ALU_OUT = 16'hCAFE; OUT_Valid = 1;
      tick();
      tick();
      wfull = 1;
      repeat (5) tick();
      chk_seq("stall_lo", 1, 8'hFE, 0, 0);
      wfull = 0;
      tick();
      chk("stall_hi_vld", TX_D_VLD, 1);
      chk_seq("stall_seq", 2, 8'hFE, 8'hCA, 0);

      // Overflow: second read dropped while the FIFO is full.
      do_reset();
      seen.delete();
      wfull = 1;
      RdData = 8'h11; RdData_Valid = 1;
      tick();
      RdData = 8'h22; RdData_Valid = 1;
      tick();
      tick();
      chk("ovf_set", OVF, 1);
      wfull = 0;
      repeat (4) tick();
      chk_seq("ovf_seq", 1, 8'h11, 0, 0);
      chk("ovf_sticky", OVF, 1);

      // Reset while the high byte is owed abandons it.
      do_reset();
      seen.delete();
      ALU_OUT = 16'hABCD; OUT_Valid = 1;
      tick();
      tick();
      do_reset();
      repeat (4) tick();
      chk_seq("rst_hi_seq", 1, 8'hCD, 0, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         ALU_OUT      = 16'($urandom);
         RdData       = 8'($urandom);
         OUT_Valid    = ($urandom_range(0, 3) == 0);
         RdData_Valid = ($urandom_range(0, 3) == 0);
         wfull        = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
